// File: rtl/core_pkg.sv
// Shared control-path definitions for the LEGv8 multicycle core.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  localparam int STAGE_FETCH     = 0;
  localparam int STAGE_DECODE    = 1;
  localparam int STAGE_EXECUTE   = 2;
  localparam int STAGE_MEMORY    = 3;
  localparam int STAGE_WRITEBACK = 4;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter; wraps modulo 2^W, cleared by asynchronous reset.
module event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// One-hot stage enable sequencer for the multicycle core: stall, memory
// handshake, halt at instruction boundary, cycle and retire counters.
module stage_sequencer
  import core_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = STAGE_MEMORY,
  parameter int COUNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          halt_req,
  input  logic                          stall,
  input  logic                          mem_ready,
  output logic                          mem_req,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          instr_retired,
  output logic [COUNT_W-1:0]            retired_count,
  output logic [COUNT_W-1:0]            cycle_count,
  output logic                          busy,
  output logic                          halted
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] MEM_IDX  = IDX_W'(MEM_STAGE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_t       state, state_next;
  logic [IDX_W-1:0] idx_next;
  logic             halt_pending, pending_next;
  logic             retire;
  logic             at_mem, advance;

  // Every output decodes registered state only, so no input reaches an output
  // combinationally.
  assign busy    = (state == RUN) || (state == MEM_WAIT);
  assign halted  = (state == HALTED);
  assign at_mem  = (stage_idx == MEM_IDX);
  assign mem_req = busy && at_mem;
  assign advance = !stall && (!at_mem || mem_ready);

  always_comb begin
    stage_en = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_en[i] = busy && (stage_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      stage_idx     <= '0;
      halt_pending  <= 1'b0;
      instr_retired <= 1'b0;
    end else begin
      state         <= state_next;
      stage_idx     <= idx_next;
      halt_pending  <= pending_next;
      instr_retired <= retire;
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = stage_idx;
    pending_next = halt_pending;
    retire       = 1'b0;
    case (state)
      IDLE: begin
        if (halt_req) begin
          state_next = HALTED;
        end else if (start) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN, MEM_WAIT: begin
        if (halt_req) pending_next = 1'b1;
        if (advance) begin
          state_next = RUN;
          if (stage_idx == LAST_IDX) begin
            retire   = 1'b1;
            idx_next = '0;
            // A halt requested in the retiring cycle still lands on this boundary.
            if (halt_pending || halt_req) begin
              state_next   = HALTED;
              pending_next = 1'b0;
            end
          end else begin
            idx_next = stage_idx + IDX_W'(1);
          end
        end else if (at_mem) begin
          state_next = MEM_WAIT;
        end else begin
          state_next = RUN;
        end
      end
      HALTED: begin
        if (start) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  event_counter #(.W(COUNT_W)) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (busy),
    .count (cycle_count)
  );

  event_counter #(.W(COUNT_W)) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (retired_count)
  );

endmodule
